// File: rtl/vga_console_writer_pkg.sv
// Shared definitions for the console writer: geometry defaults, control codes, FSM encodings.
// The cell address is packed {row, col}, matching the VGA controller's ASCII RAM port.
package vga_console_writer_pkg;

  localparam int unsigned ColsDef   = 80;
  localparam int unsigned RowsDef   = 32;
  localparam int unsigned ColBitDef = 7;
  localparam int unsigned RowBitDef = 5;
  localparam int unsigned WrHoldDef = 2;

  localparam logic [7:0] CrCh     = 8'h0D;
  localparam logic [7:0] LfCh     = 8'h0A;
  localparam logic [7:0] BsCh     = 8'h08;
  localparam logic [7:0] FfCh     = 8'h0C;
  localparam logic [7:0] SpaceCh  = 8'h20;
  localparam logic [7:0] CursorCh = 8'h5F;

  typedef enum logic [2:0] {StIdle, StWrite, StAdvance, StClrLine, StClrAll} state_e;
  typedef enum logic [2:0] {OpNone, OpPrint, OpCr, OpLf, OpBs} op_e;

  function automatic logic is_printable(logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_wr_strobe.sv
// Write-cycle timer: holds addr/data with sel_rw_o high for WrHold cycles, then one idle cycle
// flagged by done_o. A new start is accepted during that idle cycle for back-to-back writes.
module vga_wr_strobe
  import vga_console_writer_pkg::*;
#(
  parameter int unsigned AddrW  = 12,
  parameter int unsigned WrHold = WrHoldDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [7:0]       data_i,
  output logic [AddrW-1:0] waddr_o,
  output logic [7:0]       wdata_o,
  output logic             sel_rw_o,
  output logic             done_o
);

  localparam int unsigned CntW = (WrHold > 1) ? $clog2(WrHold) : 1;

  logic [CntW-1:0]  cnt_q;
  logic             sel_q, gap_q;
  logic [AddrW-1:0] addr_q;
  logic [7:0]       data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sel_q  <= 1'b0;
      gap_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (start_i && !sel_q) begin
      cnt_q  <= CntW'(WrHold - 1);
      sel_q  <= 1'b1;
      gap_q  <= 1'b0;
      addr_q <= addr_i;
      data_q <= data_i;
    end else if (sel_q) begin
      if (cnt_q == '0) begin
        sel_q <= 1'b0;
        gap_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end else begin
      gap_q <= 1'b0;
    end
  end

  assign waddr_o  = addr_q;
  assign wdata_o  = data_q;
  assign sel_rw_o = sel_q;
  assign done_o   = gap_q;

endmodule

// File: rtl/vga_console_writer.sv
// Text-terminal front end: byte handshake, hardware cursor, CR/LF/BS/FF handling, line/screen clears.
// Define VGA_CURSOR_EN to draw a '_' glyph at the cursor after every move.
module vga_console_writer
  import vga_console_writer_pkg::*;
#(
  parameter int unsigned Cols   = ColsDef,
  parameter int unsigned Rows   = RowsDef,
  parameter int unsigned ColBit = ColBitDef,
  parameter int unsigned RowBit = RowBitDef,
  parameter int unsigned WrHold = WrHoldDef
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic [31:0]       waddr_o,
  output logic [7:0]        wdata_o,
  output logic              sel_rw_o,
  output logic              busy_o,
  output logic [RowBit-1:0] cursor_row_o,
  output logic [ColBit-1:0] cursor_col_o
);

  localparam int unsigned AddrW = RowBit + ColBit;
  localparam logic [ColBit-1:0] ColMax = ColBit'(Cols - 1);
  localparam logic [RowBit-1:0] RowMax = RowBit'(Rows - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [RowBit-1:0] row_q, row_d, scan_row_q, scan_row_d, row_nxt;
  logic [ColBit-1:0] col_q, col_d, scan_col_q, scan_col_d;
  logic [7:0]        ch_q, ch_d;
  logic              first_q, first_d, last_q, last_d;
  logic              in_ready_q, in_ready_d, busy_q, busy_d;
  logic              scan_last, wrapped;
  logic              wr_start, wr_done;
  logic [AddrW-1:0]  wr_addr, wr_waddr;
  logic [7:0]        wr_data;
`ifdef VGA_CURSOR_EN
  logic              glyph_q, glyph_d, init_q, init_d;
`endif

  assign row_nxt   = (row_q == RowMax) ? '0 : row_q + RowBit'(1);
  assign scan_last = (scan_col_q == ColMax) && ((state_q == StClrLine) || (scan_row_q == RowMax));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    row_d      = row_q;
    col_d      = col_q;
    scan_row_d = scan_row_q;
    scan_col_d = scan_col_q;
    ch_d       = ch_q;
    first_d    = 1'b0;
    last_d     = last_q;
    wrapped    = 1'b0;
    wr_start   = 1'b0;
    wr_addr    = {row_q, col_q};
    wr_data    = ch_q;
`ifdef VGA_CURSOR_EN
    glyph_d    = glyph_q;
    init_d     = init_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef VGA_CURSOR_EN
        if (!init_q) begin
          init_d  = 1'b1;
          glyph_d = 1'b1;
          first_d = 1'b1;
          state_d = StWrite;
        end else
`endif
        if (in_valid_i && in_ready_q) begin
          first_d = 1'b1;
          ch_d    = in_data_i;
`ifdef VGA_CURSOR_EN
          glyph_d = 1'b0;
`endif
          if (is_printable(in_data_i)) begin
            op_d    = OpPrint;
            state_d = StWrite;
          end else if (in_data_i == FfCh) begin
            scan_row_d = '0;
            scan_col_d = '0;
            last_d     = 1'b0;
            state_d    = StClrAll;
          end else begin
            ch_d    = SpaceCh;
            state_d = StAdvance;
            if (in_data_i == CrCh)                     op_d = OpCr;
            else if (in_data_i == LfCh)                op_d = OpLf;
            else if (in_data_i == BsCh && col_q != '0) op_d = OpBs;
            else                                       op_d = OpNone;
`ifdef VGA_CURSOR_EN
            // Restore the old cell with a space before the cursor moves away.
            if (op_d != OpNone) state_d = StWrite;
`endif
          end
        end
      end
      StWrite: begin
        wr_start = first_q;
`ifdef VGA_CURSOR_EN
        wr_data = glyph_q ? CursorCh : ch_q;
        if (wr_done) state_d = glyph_q ? StIdle : StAdvance;
`else
        if (wr_done) state_d = (op_q == OpBs) ? StIdle : StAdvance;
`endif
      end
      StAdvance: begin
        state_d = StIdle;
        case (op_q)
          OpPrint: begin
            if (col_q == ColMax) begin
              col_d   = '0;
              row_d   = row_nxt;
              wrapped = 1'b1;
            end else begin
              col_d = col_q + ColBit'(1);
            end
          end
          OpCr: col_d = '0;
          OpLf: begin
            col_d   = '0;
            row_d   = row_nxt;
            wrapped = 1'b1;
          end
          OpBs:    col_d = col_q - ColBit'(1);
          default: ;
        endcase
        if (wrapped) begin
          scan_row_d = row_nxt;
          scan_col_d = '0;
          last_d     = 1'b0;
          first_d    = 1'b1;
          state_d    = StClrLine;
`ifdef VGA_CURSOR_EN
        end else if (op_q != OpNone) begin
          glyph_d = 1'b1;
          first_d = 1'b1;
          state_d = StWrite;
`else
        end else if (op_q == OpBs) begin
          first_d = 1'b1;
          state_d = StWrite;
`endif
        end
      end
      StClrLine, StClrAll: begin
        wr_addr  = {scan_row_q, scan_col_q};
        wr_data  = SpaceCh;
        // Scan registers point at the next cell to issue; last_q marks the final one in flight.
        wr_start = first_q || (wr_done && !last_q);
        if (wr_start) begin
          last_d = scan_last;
          if (scan_col_q == ColMax) begin
            scan_col_d = '0;
            scan_row_d = (scan_row_q == RowMax) ? '0 : scan_row_q + RowBit'(1);
          end else begin
            scan_col_d = scan_col_q + ColBit'(1);
          end
        end
        if (wr_done && last_q) begin
          if (state_q == StClrAll) begin
            row_d = '0;
            col_d = '0;
          end
`ifdef VGA_CURSOR_EN
          glyph_d = 1'b1;
          first_d = 1'b1;
          state_d = StWrite;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready_d = (state_d == StIdle);
  assign busy_d     = (state_d != StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_q       <= OpNone;
      row_q      <= '0;
      col_q      <= '0;
      scan_row_q <= '0;
      scan_col_q <= '0;
      ch_q       <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef VGA_CURSOR_EN
      glyph_q    <= 1'b0;
      init_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      row_q      <= row_d;
      col_q      <= col_d;
      scan_row_q <= scan_row_d;
      scan_col_q <= scan_col_d;
      ch_q       <= ch_d;
      first_q    <= first_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
`ifdef VGA_CURSOR_EN
      glyph_q    <= glyph_d;
      init_q     <= init_d;
`endif
    end
  end

  vga_wr_strobe #(
    .AddrW  (AddrW),
    .WrHold (WrHold)
  ) u_wr_strobe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (wr_start),
    .addr_i   (wr_addr),
    .data_i   (wr_data),
    .waddr_o  (wr_waddr),
    .wdata_o  (wdata_o),
    .sel_rw_o (sel_rw_o),
    .done_o   (wr_done)
  );

  assign waddr_o      = 32'(wr_waddr);
  assign in_ready_o   = in_ready_q;
  assign busy_o       = busy_q;
  assign cursor_row_o = row_q;
  assign cursor_col_o = col_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Scoreboard bench for vga_console_writer (default build, no cursor glyph): a terminal model
// queues the expected RAM writes per byte; a monitor pops them on every rising write strobe.
module tb_vga_console_writer;

  localparam int COLS    = 80;
  localparam int ROWS    = 32;
  localparam int WR_HOLD = 2;
  localparam int BUDGET  = 20000;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic        clk, rst_n, in_valid, in_ready, sel, busy;
  logic [7:0]  in_data, wdata;
  logic [31:0] waddr;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;
  int  m_row = 0, m_col = 0;
  int  wr_count = 0;

  vga_console_writer u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .sel_rw_o     (sel),
    .busy_o       (busy),
    .cursor_row_o (cur_row),
    .cursor_col_o (cur_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference terminal: cell address is row * 2**7 + col.
  task automatic push_wr(input int r, input int c, input int d);
    exp_q.push_back('{addr: r * 128 + c, data: d});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_row, m_col, b);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push_wr(m_row, c, 8'h20);
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      for (int c = 0; c < COLS; c++) push_wr(m_row, c, 8'h20);
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row, m_col, 8'h20);
      end
    end else if (b == 8'h0C) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) push_wr(r, c, 8'h20);
      m_row = 0;
      m_col = 0;
    end
  endtask

  // Monitor: pop on each rising strobe, check hold length and address stability.
  int   hold = 0;
  logic prev_sel = 1'b0;
  int   cur_addr = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sel = 1'b0;
      hold     = 0;
    end else begin
      if (sel && !prev_sel) begin
        wr_count++;
        check("in_ready low during write", int'(in_ready), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected write: actual addr=0x%0h data=0x%0h required none", waddr, wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write addr", int'(waddr), e.addr);
          check("write data", int'(wdata), e.data);
        end
        cur_addr = int'(waddr);
        hold     = 1;
      end else if (sel) begin
        hold++;
        check("addr stable while held", int'(waddr), cur_addr);
      end
      if (!sel && prev_sel) check("selRW hold cycles", hold, WR_HOLD);
      prev_sel = sel;
    end
  end

  task automatic send(input logic [7:0] b);
    for (int i = 0; i < BUDGET; i++) begin
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    check("in_ready before send", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = b;
    model_byte(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_idle_check();
    int cyc;
    for (cyc = 0; cyc < BUDGET; cyc++) begin
      if (in_ready && !busy) break;
      @(posedge clk);
      #1;
    end
    check("idle within budget", int'(cyc < BUDGET), 1);
    check("cursor_row", int'(cur_row), m_row);
    check("cursor_col", int'(cur_col), m_col);
    check("pending writes", exp_q.size(), 0);
  endtask

  task automatic do_byte(input logic [7:0] b);
    send(b);
    wait_idle_check();
  endtask

  initial begin
    int wc0;
    int pick;
    logic [7:0] rb;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset sel", int'(sel), 0);
    check("reset in_ready", int'(in_ready), 0);
    check("reset busy", int'(busy), 0);
    check("reset waddr", int'(waddr), 0);
    check("reset wdata", int'(wdata), 0);
    check("reset cursor", int'({cur_row, cur_col}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready after reset exit", int'(in_ready), 1);

    // Single printable
    wc0 = wr_count;
    do_byte(8'h41);
    check("'A' write count", wr_count - wc0, 1);

    // Line wrap after 80 characters clears the next row
    do_byte(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'h78);
    wait_idle_check();

    // Full screen clear
    wc0 = wr_count;
    do_byte(8'h0C);
    check("FF write count", wr_count - wc0, ROWS * COLS);

    // LF from the last row wraps to row 0
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    wait_idle_check();
    check("cursor at (31,5)", int'({cur_row, cur_col}), (31 << 7) + 5);
    do_byte(8'h0A);

    // Backspace edges and a dropped control byte
    do_byte(8'h0A);
    do_byte(8'h0A);
    do_byte(8'h0A);
    wc0 = wr_count;
    do_byte(8'h08);
    check("BS at col 0 writes", wr_count - wc0, 0);
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
    wait_idle_check();
    wc0 = wr_count;
    do_byte(8'h08);
    check("BS at col 4 writes", wr_count - wc0, 1);
    wc0 = wr_count;
    do_byte(8'h07);
    check("BEL writes", wr_count - wc0, 0);

    // Randomized byte stream
    for (int i = 0; i < 150; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 65)      rb = 8'($urandom_range(32, 126));
      else if (pick < 75) rb = 8'h0D;
      else if (pick < 83) rb = 8'h0A;
      else if (pick < 93) rb = 8'h08;
      else                rb = 8'($urandom_range(128, 255));
      do_byte(rb);
    end

    // Reset in the middle of a screen clear
    do_byte(8'h51);
    send(8'h0C);
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid-reset sel", int'(sel), 0);
    check("mid-reset in_ready", int'(in_ready), 0);
    check("mid-reset busy", int'(busy), 0);
    check("mid-reset cursor", int'({cur_row, cur_col}), 0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wc0 = wr_count;
    do_byte(8'h42);
    check("'B' after reset write count", wr_count - wc0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
